// File: rtl/gp_axis_pingpong_interface.sv
// gp_axis_pingpong_interface: ping-pong AXIS input banks feeding a start/done core, output buffer streamed with TLAST.
// Optional GP_AXIS_PINGPONG_STATS_EN adds frames_in/frames_out counters.
module gp_axis_pingpong_interface #(
    parameter int DATA_WIDTH   = 32,
    parameter int IN_DATA_NUM  = 8,
    parameter int OUT_DATA_NUM = 4,
    parameter int IN_ADR_W     = $clog2(IN_DATA_NUM),
    parameter int OUT_ADR_W    = $clog2(OUT_DATA_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  axisif_start,
    input  logic                  axisif_done,
    output logic                  axisif_bank,
    input  logic [IN_ADR_W-1:0]   axisif_bufferIn_adr,
    output logic [DATA_WIDTH-1:0] axisif_bufferIn_data,
    input  logic [OUT_ADR_W-1:0]  axisif_bufferOut_adr,
    input  logic [DATA_WIDTH-1:0] axisif_bufferOut_data,
    input  logic                  axisif_bufferOut_wr,
    output logic                  err_len
`ifdef GP_AXIS_PINGPONG_STATS_EN
    ,
    output logic [15:0]           frames_in,
    output logic [15:0]           frames_out
`endif
);
    typedef enum logic {RX_FILL, RX_DROP} rx_t;
    typedef enum logic [2:0] {C_IDLE, C_START, C_WAIT_LO, C_WAIT_HI, C_SEND} c_t;

    localparam logic [IN_ADR_W-1:0]  K_LAST = IN_ADR_W'(IN_DATA_NUM - 1);
    localparam logic [OUT_ADR_W-1:0] J_LAST = OUT_ADR_W'(OUT_DATA_NUM - 1);

    rx_t rx_state, rx_next;
    c_t c_state, c_next;
    logic run, wr_bank, rd_bank, bank;
    logic [1:0] full;
    logic [IN_ADR_W-1:0] k;
    logic [OUT_ADR_W-1:0] j;
    logic [DATA_WIDTH-1:0] in_buf [2][IN_DATA_NUM];
    logic [DATA_WIDTH-1:0] out_buf [OUT_DATA_NUM];
    logic accept, at_end, fill_set, err_set, release_bank, send, beat;

    // run holds s_ready low until the first clock after reset release
    assign s_ready      = run && (rx_state == RX_DROP || !full[wr_bank]);
    assign accept       = s_valid && s_ready;
    assign at_end       = k == K_LAST;
    assign fill_set     = accept && rx_state == RX_FILL && at_end;
    assign err_set      = accept && rx_state == RX_FILL && (at_end != s_last);
    assign send         = c_state == C_SEND;
    assign m_valid      = send;
    assign m_last       = send && j == J_LAST;
    assign m_data       = send ? out_buf[j] : '0;
    assign beat         = m_valid && m_ready;
    assign release_bank = c_state == C_WAIT_HI && axisif_done;
    assign axisif_start = c_state == C_START;
    assign axisif_bank  = bank;
    assign axisif_bufferIn_data = in_buf[bank][axisif_bufferIn_adr];

    always_comb begin
        rx_next = rx_state;
        if (rx_state == RX_FILL && fill_set && !s_last)
            rx_next = RX_DROP;
        else if (rx_state == RX_DROP && accept && s_last)
            rx_next = RX_FILL;
    end

    always_comb begin
        c_next = c_state;
        case (c_state)
            C_IDLE:    c_next = (full[rd_bank] && axisif_done) ? C_START : C_IDLE;
            C_START:   c_next = C_WAIT_LO;
            C_WAIT_LO: c_next = axisif_done ? C_WAIT_LO : C_WAIT_HI;
            C_WAIT_HI: c_next = axisif_done ? C_SEND : C_WAIT_HI;
            C_SEND:    c_next = (beat && m_last) ? C_IDLE : C_SEND;
            default:   c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            rx_state <= RX_FILL;
            c_state  <= C_IDLE;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            bank     <= 1'b0;
            full     <= '0;
            k        <= '0;
            j        <= '0;
            err_len  <= 1'b0;
        end else begin
            run      <= 1'b1;
            rx_state <= rx_next;
            c_state  <= c_next;
            // fill and release always target different banks, so both apply
            full     <= (full | (fill_set ? 2'b01 << wr_bank : 2'b00))
                        & ~(release_bank ? 2'b01 << rd_bank : 2'b00);
            if (fill_set)
                wr_bank <= !wr_bank;
            if (accept && rx_state == RX_FILL)
                k <= (at_end || s_last) ? '0 : k + 1'b1;
            if (err_set)
                err_len <= 1'b1;
            if (c_state == C_IDLE && c_next == C_START)
                bank <= rd_bank;
            if (release_bank)
                rd_bank <= !rd_bank;
            if (beat)
                j <= m_last ? '0 : j + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && rx_state == RX_FILL)
            in_buf[wr_bank][k] <= s_data;
        if (axisif_bufferOut_wr)
            out_buf[axisif_bufferOut_adr] <= axisif_bufferOut_data;
    end

`ifdef GP_AXIS_PINGPONG_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_in  <= '0;
            frames_out <= '0;
        end else begin
            if (fill_set)
                frames_in <= frames_in + 1'b1;
            if (beat && m_last)
                frames_out <= frames_out + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_gp_axis_pingpong_interface.sv
// tb_gp_axis_pingpong_interface: directed scenarios with a behavioural core and stream sink.
module tb_gp_axis_pingpong_interface;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] s_data = 0;
    logic        s_valid = 0;
    logic        s_last = 0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 0;
    logic        axisif_start;
    logic        axisif_done = 1;
    logic        axisif_bank;
    logic [2:0]  in_adr = 0;
    logic [31:0] in_data;
    logic [1:0]  out_adr = 0;
    logic [31:0] out_data = 0;
    logic        out_wr = 0;
    logic        err_len;
`ifdef GP_AXIS_PINGPONG_STATS_EN
    logic [15:0] frames_in, frames_out;
`endif
    int tests = 0;
    int fails = 0;
    int start_cnt = 0;

    gp_axis_pingpong_interface dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .axisif_start(axisif_start), .axisif_done(axisif_done), .axisif_bank(axisif_bank),
        .axisif_bufferIn_adr(in_adr), .axisif_bufferIn_data(in_data),
        .axisif_bufferOut_adr(out_adr), .axisif_bufferOut_data(out_data),
        .axisif_bufferOut_wr(out_wr), .err_len(err_len)
`ifdef GP_AXIS_PINGPONG_STATS_EN
        , .frames_in(frames_in), .frames_out(frames_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (axisif_start) start_cnt++;

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        s_data = d; s_valid = 1; s_last = l;
        while (!s_ready && n < 500) begin @(negedge clk); n++; end
        if (!s_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout data=%0d s_ready=%b required 1", d, s_ready);
        end
        @(negedge clk);
        s_valid = 0; s_last = 0;
    endtask

    task automatic send_frame(input int base, input int n, input int last_at);
        for (int i = 0; i < n; i++) send_beat(32'(base + i), (i + 1) == last_at);
    endtask

    task automatic core_run(input int busy, input logic exp_bank, input int exp_base, input int obase);
        int n = 0;
        int bad = 0;
        logic [31:0] first_got = 0;
        while (!axisif_start && n < 2000) begin @(negedge clk); n++; end
        tests++;
        if (!axisif_start) begin
            fails++; $display("FAIL start_timeout start=%b required 1", axisif_start);
        end
        tests++;
        if (axisif_bank !== exp_bank) begin
            fails++; $display("FAIL start_bank got=%b required %b", axisif_bank, exp_bank);
        end
        axisif_done = 0;
        for (int i = 0; i < 8; i++) begin
            in_adr = 3'(i); #1;
            if (in_data !== 32'(exp_base + i)) begin
                if (bad == 0) first_got = in_data;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL core_read bad_words=%0d first_got=%0d required base %0d", bad, first_got, exp_base);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); out_wr = 1; out_adr = 2'(i); out_data = 32'(obase + i);
        end
        @(negedge clk); out_wr = 0;
        repeat (busy) @(negedge clk);
        axisif_done = 1;
    endtask

    task automatic recv_frame(input int obase, input int mode);
        int beats = 0, lasts = 0, cyc = 0, c = 0, bad = 0, stall_bad = 0;
        logic held = 0;
        logic hl = 0;
        logic [31:0] hd = 0;
        while (beats < 4 && cyc < 3000) begin
            m_ready = (mode == 0) || (c >= 5 && c % 2 == 1);
            if (m_valid) begin
                if (held && (m_data !== hd || m_last !== hl)) stall_bad++;
                if (m_ready) begin
                    if (m_data !== 32'(obase + beats) || m_last !== (beats == 3)) bad++;
                    if (m_last) lasts++;
                    beats++; held = 0;
                end else begin
                    held = 1; hd = m_data; hl = m_last;
                end
                c++;
            end
            cyc++;
            @(negedge clk);
        end
        m_ready = 0;
        tests++;
        if (beats != 4) begin fails++; $display("FAIL out_beats got=%0d required 4", beats); end
        tests++;
        if (lasts != 1) begin fails++; $display("FAIL out_last_count got=%0d required 1", lasts); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL out_data bad_beats=%0d required 0 (base %0d)", bad, obase); end
        tests++;
        if (stall_bad != 0) begin fails++; $display("FAIL out_stable changes=%0d required 0", stall_bad); end
        tests++;
        if (m_valid !== 0) begin fails++; $display("FAIL out_valid_drop got=%b required 0", m_valid); end
    endtask

    task automatic test_reset;
        rst_n = 0; #2;
        tests++;
        if ({s_ready, m_valid, m_last, axisif_start, axisif_bank, err_len} !== 6'b0 || m_data !== 0) begin
            fails++;
            $display("FAIL reset_outputs got=%b%b%b%b%b%b data=%0d required all 0",
                     s_ready, m_valid, m_last, axisif_start, axisif_bank, err_len, m_data);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        tests++;
        if (s_ready !== 0) begin fails++; $display("FAIL reset_ready_early got=%b required 0", s_ready); end
        @(negedge clk);
        tests++;
        if (s_ready !== 1) begin fails++; $display("FAIL reset_ready_rise got=%b required 1", s_ready); end
    endtask

    task automatic test_single;
        int s0 = start_cnt;
        fork
            send_frame(1, 8, 8);
            core_run(5, 0, 1, 2);
        join
        recv_frame(2, 0);
        tests++;
        if (start_cnt - s0 != 1) begin fails++; $display("FAIL single_starts got=%0d required 1", start_cnt - s0); end
        tests++;
        if (err_len !== 0) begin fails++; $display("FAIL single_err got=%b required 0", err_len); end
    endtask

    task automatic test_overlap;
        fork
            begin
                send_frame(1, 8, 8);
                send_frame(11, 8, 8);
                tests++;
                if (axisif_done !== 0) begin
                    fails++; $display("FAIL overlap_accept_busy done=%b required 0", axisif_done);
                end
            end
            begin
                core_run(30, 1, 1, 100);
                recv_frame(100, 0);
                core_run(5, 0, 11, 200);
                recv_frame(200, 0);
            end
        join
    endtask

    task automatic test_backpressure;
        fork
            send_frame(31, 8, 8);
            core_run(3, 1, 31, 40);
        join
        recv_frame(40, 1);
    endtask

    task automatic test_stall;
        fork
            begin
                send_frame(101, 8, 8);
                send_frame(111, 8, 8);
                tests++;
                if (s_ready !== 0) begin fails++; $display("FAIL stall_ready got=%b required 0", s_ready); end
                repeat (10) @(negedge clk);
                tests++;
                if (s_ready !== 0) begin fails++; $display("FAIL stall_ready_hold got=%b required 0", s_ready); end
                send_frame(121, 8, 8);
            end
            begin
                core_run(40, 0, 101, 140);
                recv_frame(140, 0);
                core_run(3, 1, 111, 150);
                recv_frame(150, 0);
                core_run(3, 0, 121, 160);
                recv_frame(160, 0);
            end
        join
    endtask

    task automatic test_length;
        int s0;
        tests++;
        if (err_len !== 0) begin fails++; $display("FAIL len_err_clean got=%b required 0", err_len); end
        s0 = start_cnt;
        send_frame(1, 5, 5);
        repeat (10) @(negedge clk);
        tests++;
        if (start_cnt != s0) begin fails++; $display("FAIL early_last_start got=%0d required 0", start_cnt - s0); end
        tests++;
        if (err_len !== 1) begin fails++; $display("FAIL early_last_err got=%b required 1", err_len); end
        fork
            send_frame(1, 10, 10);
            core_run(3, 1, 1, 300);
        join
        recv_frame(300, 0);
        tests++;
        if (start_cnt - s0 != 1) begin fails++; $display("FAIL long_frame_starts got=%0d required 1", start_cnt - s0); end
        tests++;
        if (err_len !== 1) begin fails++; $display("FAIL long_frame_err got=%b required 1", err_len); end
    endtask

    task automatic test_reset_mid_send;
        int beats = 0, cyc = 0;
        fork
            send_frame(51, 8, 8);
            core_run(3, 0, 51, 60);
        join
        m_ready = 1;
        while (beats < 2 && cyc < 500) begin
            if (m_valid) beats++;
            cyc++;
            @(negedge clk);
        end
        m_ready = 0;
        tests++;
        if (m_data !== 62) begin fails++; $display("FAIL mid_send_data got=%0d required 62", m_data); end
        #2 rst_n = 0;
        #1;
        tests++;
        if (m_valid !== 0 || m_data !== 0 || s_ready !== 0) begin
            fails++; $display("FAIL async_reset valid=%b data=%0d ready=%b required 0", m_valid, m_data, s_ready);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        tests++;
        if (s_ready !== 1 || err_len !== 0 || axisif_bank !== 0) begin
            fails++; $display("FAIL post_reset ready=%b err=%b bank=%b required 1 0 0", s_ready, err_len, axisif_bank);
        end
`ifdef GP_AXIS_PINGPONG_STATS_EN
        tests++;
        if (frames_in !== 0 || frames_out !== 0) begin
            fails++; $display("FAIL stats_reset in=%0d out=%0d required 0 0", frames_in, frames_out);
        end
`endif
        fork
            send_frame(71, 8, 8);
            core_run(3, 0, 71, 80);
        join
        recv_frame(80, 0);
`ifdef GP_AXIS_PINGPONG_STATS_EN
        tests++;
        if (frames_in !== 1 || frames_out !== 1) begin
            fails++; $display("FAIL stats_count in=%0d out=%0d required 1 1", frames_in, frames_out);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_backpressure();
        test_stall();
        test_length();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
